// File: rtl/iom_bus_master.sv
// T1-T4 bus-cycle master for the IOM memory/IO slaves: sequences ALE, RD/WR,
// address, one-hot chip selects and the shared data bus from a one-cycle request.
//
// state | meaning
// IDLE  | waiting for req; latches the request when it arrives
// T1    | ALE high, address and chip select presented
// T2    | RD or WR strobe asserted
// TW    | strobe held for WAIT_STATES extra cycles
// T3    | strobe held; read data captured on exit
// T4    | strobes and cs dropped, done pulses
module iom_bus_master #(
  parameter int Add_width   = 20,
  parameter int Data_width  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_wr,
  input  logic                  req_io,
  input  logic [Add_width-1:0]  req_addr,
  input  logic [Data_width-1:0] req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [Data_width-1:0] rdata,
  output logic                  ALE,
  output logic                  RD,
  output logic                  WR,
  output logic [Add_width-1:0]  Addr,
  output logic [3:0]            cs,
  inout  wire  [Data_width-1:0] data
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

  state_t                state, state_nxt;
  logic                  wr_q;
  logic                  io_q;
  logic [Add_width-1:0]  addr_q;
  logic [Data_width-1:0] wdata_q;
  logic [3:0]            wait_cnt;
  logic                  strobe_phase;
  logic                  cs_phase;
  logic [3:0]            cs_dec;

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = T1;
      T1:      state_nxt = T2;
      T2:      state_nxt = (WAIT_STATES > 0) ? TW : T3;
      TW:      if (wait_cnt == 4'd1) state_nxt = T3;
      T3:      state_nxt = T4;
      T4:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      wr_q    <= req_wr;
      io_q    <= req_io;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst)              wait_cnt <= '0;
    else if (state == T2) wait_cnt <= 4'(WAIT_STATES);
    else if (state == TW) wait_cnt <= wait_cnt - 4'd1;
  end

  // Reset clears rdata only from an idle bus so an aborted transfer keeps the last read value.
  always_ff @(posedge CLK) begin
    if (rst) begin
      if (!busy) rdata <= '0;
    end else if (state == T3 && !wr_q) begin
      rdata <= data;
    end
  end

  always_comb begin
    case ({io_q, addr_q[Add_width-1]})
      2'b00:   cs_dec = 4'b0001;
      2'b01:   cs_dec = 4'b0010;
      2'b10:   cs_dec = 4'b0100;
      default: cs_dec = 4'b1000;
    endcase
  end

  assign strobe_phase = (state == T2) || (state == TW) || (state == T3);
  assign cs_phase     = (state == T1) || strobe_phase;

  assign busy = (state != IDLE);
  assign done = (state == T4);
  assign ALE  = (state == T1);
  assign RD   = strobe_phase && !wr_q;
  assign WR   = strobe_phase &&  wr_q;
  assign Addr = addr_q;
  assign cs   = cs_phase ? cs_dec : 4'b0000;
  assign data = (strobe_phase && wr_q) ? wdata_q : {Data_width{1'bz}};

endmodule
